// File: rtl/sound_mixer_pkg.sv
// rtl/sound_mixer_pkg.sv - shared types, addresses and volume scaling for the sound mixer
`include "memdef.vh"

package sound_mixer_pkg;

  localparam logic [15:0] NR50_ADDR = `MEM_NR50_ADDR;
  localparam logic [15:0] NR51_ADDR = `MEM_NR51_ADDR;
  localparam logic [15:0] NR52_ADDR = `MEM_NR52_ADDR;

  localparam int SAMPLE_W = 20;
  localparam int ACC_W    = 22;
  localparam int SCALE_W  = 25;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACC0  = 3'd1,
    ST_ACC1  = 3'd2,
    ST_ACC2  = 3'd3,
    ST_ACC3  = 3'd4,
    ST_SCALE = 3'd5,
    ST_OUT   = 3'd6
  } mix_state_t;

  // Volume step is (vol+1)/8; anything above 20 bits clips to full scale.
  function automatic logic [SAMPLE_W-1:0] scale_sat(input logic [ACC_W-1:0] acc,
                                                    input logic [2:0] vol);
    logic [SCALE_W-1:0] prod;
    logic [SCALE_W-1:0] shifted;
    prod    = SCALE_W'(acc) * (SCALE_W'(vol) + SCALE_W'(1));
    shifted = prod >> 3;
    if (shifted[SCALE_W-1:SAMPLE_W] != '0) begin
      return {SAMPLE_W{1'b1}};
    end
    return shifted[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/io_bus_parser_reg.sv
// rtl/io_bus_parser_reg.sv - one 8-bit IO register with a write port and read decode
module io_bus_parser_reg #(
  parameter logic [15:0] P_REG_ADDR = 16'h0000
) (
  input  logic        I_CLK,
  input  logic        I_RESET,
  input  logic [15:0] I_IOREG_ADDR,
  input  logic        I_IOREG_RE_L,
  input  logic [7:0]  I_DATA_WR,
  input  logic        I_REG_WR_EN,
  output logic [7:0]  O_REG,
  output logic        O_RD_HIT
);

  logic [7:0] reg_q, reg_d;

  always_comb begin
    reg_d = reg_q;
    if (I_REG_WR_EN) begin
      reg_d = I_DATA_WR;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      reg_q <= '0;
    end else begin
      reg_q <= reg_d;
    end
  end

  assign O_REG    = reg_q;
  assign O_RD_HIT = !I_IOREG_RE_L && (I_IOREG_ADDR == P_REG_ADDR);

endmodule

// File: rtl/memdef.vh
// rtl/memdef.vh - IO register addresses for the sound mixer
`ifndef MEMDEF_VH
`define MEMDEF_VH
`define MEM_NR50_ADDR 16'hFF24
`define MEM_NR51_ADDR 16'hFF25
`define MEM_NR52_ADDR 16'hFF26
`endif

// File: rtl/sound_mixer.sv
// rtl/sound_mixer.sv - four-channel stereo mixer with NR50/NR51/NR52 register control
module sound_mixer
  import sound_mixer_pkg::*;
(
  input  logic                I_CLK,
  input  logic                I_RESET,
  input  logic [15:0]         I_IOREG_ADDR,
  inout  wire  [7:0]          IO_IOREG_DATA,
  input  logic                I_IOREG_WE_L,
  input  logic                I_IOREG_RE_L,
  input  logic [SAMPLE_W-1:0] I_CH1_WAVEFORM,
  input  logic [SAMPLE_W-1:0] I_CH2_WAVEFORM,
  input  logic [SAMPLE_W-1:0] I_CH3_WAVEFORM,
  input  logic [SAMPLE_W-1:0] I_CH4_WAVEFORM,
  input  logic                I_CH1_ON,
  input  logic                I_CH2_ON,
  input  logic                I_CH3_ON,
  input  logic                I_CH4_ON,
  input  logic                I_SAMPLE_REQ,
  output logic [SAMPLE_W-1:0] O_LEFT,
  output logic [SAMPLE_W-1:0] O_RIGHT,
  output logic                O_SAMPLE_VALID,
  output logic                O_OVERRUN,
  output logic                O_SOUND_ON
);

  logic [7:0] nr50, nr51;
  logic       nr50_rd_hit, nr51_rd_hit, nr52_rd_hit;
  logic       wr_nr50_hit, wr_nr51_hit, wr_nr52_hit;
  logic       clear_regs;
  logic       nr50_we, nr51_we;
  logic [7:0] nr50_wdata, nr51_wdata;
  logic [7:0] rd_data;
  logic       master_en_q, master_en_d;

  assign wr_nr50_hit = !I_IOREG_WE_L && (I_IOREG_ADDR == NR50_ADDR);
  assign wr_nr51_hit = !I_IOREG_WE_L && (I_IOREG_ADDR == NR51_ADDR);
  assign wr_nr52_hit = !I_IOREG_WE_L && (I_IOREG_ADDR == NR52_ADDR);
  assign nr52_rd_hit = !I_IOREG_RE_L && (I_IOREG_ADDR == NR52_ADDR);

  // Registers are held clear for as long as the master enable is off.
  assign clear_regs = !master_en_q || (wr_nr52_hit && !IO_IOREG_DATA[7]);
  assign nr50_we    = clear_regs || wr_nr50_hit;
  assign nr51_we    = clear_regs || wr_nr51_hit;
  assign nr50_wdata = clear_regs ? 8'h00 : IO_IOREG_DATA;
  assign nr51_wdata = clear_regs ? 8'h00 : IO_IOREG_DATA;

  io_bus_parser_reg #(.P_REG_ADDR(NR50_ADDR)) u_nr50 (
    .I_CLK        (I_CLK),
    .I_RESET      (I_RESET),
    .I_IOREG_ADDR (I_IOREG_ADDR),
    .I_IOREG_RE_L (I_IOREG_RE_L),
    .I_DATA_WR    (nr50_wdata),
    .I_REG_WR_EN  (nr50_we),
    .O_REG        (nr50),
    .O_RD_HIT     (nr50_rd_hit)
  );

  io_bus_parser_reg #(.P_REG_ADDR(NR51_ADDR)) u_nr51 (
    .I_CLK        (I_CLK),
    .I_RESET      (I_RESET),
    .I_IOREG_ADDR (I_IOREG_ADDR),
    .I_IOREG_RE_L (I_IOREG_RE_L),
    .I_DATA_WR    (nr51_wdata),
    .I_REG_WR_EN  (nr51_we),
    .O_REG        (nr51),
    .O_RD_HIT     (nr51_rd_hit)
  );

  always_comb begin
    master_en_d = master_en_q;
    if (wr_nr52_hit) begin
      master_en_d = IO_IOREG_DATA[7];
    end
  end

  always_comb begin
    rd_data = 8'h00;
    if (nr50_rd_hit) begin
      rd_data = nr50;
    end else if (nr51_rd_hit) begin
      rd_data = nr51;
    end else if (nr52_rd_hit) begin
      rd_data = {master_en_q, 3'b111, I_CH4_ON, I_CH3_ON, I_CH2_ON, I_CH1_ON};
    end
  end

  assign IO_IOREG_DATA = (nr50_rd_hit || nr51_rd_hit || nr52_rd_hit) ? rd_data : 8'hzz;

  mix_state_t          state_q, state_d;
  logic [SAMPLE_W-1:0] cap_q [4];
  logic [SAMPLE_W-1:0] cap_d [4];
  logic [ACC_W-1:0]    acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [SAMPLE_W-1:0] scaled_l_q, scaled_l_d, scaled_r_q, scaled_r_d;
  logic [SAMPLE_W-1:0] out_l_q, out_l_d, out_r_q, out_r_d;
  logic                valid_q, valid_d, overrun_q, overrun_d;
  logic [1:0]          acc_idx;

  always_comb begin
    state_d    = state_q;
    cap_d      = cap_q;
    acc_l_d    = acc_l_q;
    acc_r_d    = acc_r_q;
    scaled_l_d = scaled_l_q;
    scaled_r_d = scaled_r_q;
    out_l_d    = out_l_q;
    out_r_d    = out_r_q;
    valid_d    = 1'b0;
    overrun_d  = 1'b0;
    acc_idx    = 2'(state_q - ST_ACC0);

    case (state_q)
      ST_IDLE: begin
        if (I_SAMPLE_REQ) begin
          cap_d[0] = I_CH1_ON ? I_CH1_WAVEFORM : '0;
          cap_d[1] = I_CH2_ON ? I_CH2_WAVEFORM : '0;
          cap_d[2] = I_CH3_ON ? I_CH3_WAVEFORM : '0;
          cap_d[3] = I_CH4_ON ? I_CH4_WAVEFORM : '0;
          acc_l_d  = '0;
          acc_r_d  = '0;
          state_d  = ST_ACC0;
        end
      end
      ST_ACC0, ST_ACC1, ST_ACC2, ST_ACC3: begin
        if (nr51[{1'b1, acc_idx}]) acc_l_d = acc_l_q + ACC_W'(cap_q[acc_idx]);
        if (nr51[{1'b0, acc_idx}]) acc_r_d = acc_r_q + ACC_W'(cap_q[acc_idx]);
        state_d = (state_q == ST_ACC3) ? ST_SCALE : mix_state_t'(state_q + 3'd1);
      end
      ST_SCALE: begin
        scaled_l_d = scale_sat(acc_l_q, nr50[6:4]);
        scaled_r_d = scale_sat(acc_r_q, nr50[2:0]);
        state_d    = ST_OUT;
      end
      ST_OUT: begin
        out_l_d = scaled_l_q;
        out_r_d = scaled_r_q;
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE && I_SAMPLE_REQ) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      master_en_q <= 1'b0;
      state_q     <= ST_IDLE;
      for (int i = 0; i < 4; i++) cap_q[i] <= '0;
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      scaled_l_q  <= '0;
      scaled_r_q  <= '0;
      out_l_q     <= '0;
      out_r_q     <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      master_en_q <= master_en_d;
      state_q     <= state_d;
      cap_q       <= cap_d;
      acc_l_q     <= acc_l_d;
      acc_r_q     <= acc_r_d;
      scaled_l_q  <= scaled_l_d;
      scaled_r_q  <= scaled_r_d;
      out_l_q     <= out_l_d;
      out_r_q     <= out_r_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign O_LEFT         = master_en_q ? out_l_q : '0;
  assign O_RIGHT        = master_en_q ? out_r_q : '0;
  assign O_SAMPLE_VALID = valid_q;
  assign O_OVERRUN      = overrun_q;
  assign O_SOUND_ON     = master_en_q;

endmodule

// File: tb/tb_sound_mixer.sv
// tb/tb_sound_mixer.sv - directed self-checking bench for sound_mixer
module tb_sound_mixer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic        we_l = 1'b1;
  logic        re_l = 1'b1;
  logic [7:0]  tb_wdata = 8'h00;
  logic        tb_drive = 1'b0;
  wire  [7:0]  io_data;
  logic [19:0] ch_wave [4];
  logic [3:0]  ch_on = 4'h0;
  logic        req = 1'b0;
  logic [19:0] o_left, o_right;
  logic        o_valid, o_overrun, o_sound_on;

  int n_cmp  = 0;
  int n_fail = 0;
  int valid_at, ovr_at, n_valid, n_ovr;
  logic [7:0] rd;

  assign io_data = tb_drive ? tb_wdata : 8'hzz;

  always #5 clk = ~clk;

  sound_mixer dut (
    .I_CLK          (clk),
    .I_RESET        (rst),
    .I_IOREG_ADDR   (addr),
    .IO_IOREG_DATA  (io_data),
    .I_IOREG_WE_L   (we_l),
    .I_IOREG_RE_L   (re_l),
    .I_CH1_WAVEFORM (ch_wave[0]),
    .I_CH2_WAVEFORM (ch_wave[1]),
    .I_CH3_WAVEFORM (ch_wave[2]),
    .I_CH4_WAVEFORM (ch_wave[3]),
    .I_CH1_ON       (ch_on[0]),
    .I_CH2_ON       (ch_on[1]),
    .I_CH3_ON       (ch_on[2]),
    .I_CH4_ON       (ch_on[3]),
    .I_SAMPLE_REQ   (req),
    .O_LEFT         (o_left),
    .O_RIGHT        (o_right),
    .O_SAMPLE_VALID (o_valid),
    .O_OVERRUN      (o_overrun),
    .O_SOUND_ON     (o_sound_on)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; tb_wdata = d; tb_drive = 1'b1; we_l = 1'b0;
    @(negedge clk);
    we_l = 1'b1; tb_drive = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = a; re_l = 1'b0;
    #1 d = io_data;
    re_l = 1'b1;
  endtask

  task automatic set_ch(input logic [19:0] w1, w2, w3, w4, input logic [3:0] on);
    ch_wave[0] = w1; ch_wave[1] = w2; ch_wave[2] = w3; ch_wave[3] = w4;
    ch_on = on;
  endtask

  // Request sampled at edge k; sample index i is taken in the cycle after edge k+i.
  // Channel inputs are scrambled right after capture to prove they are not re-read.
  task automatic run_sample(input int rereq, input int rst_at,
                            output int v_at, output int o_at, output int nv, output int no);
    v_at = -1; o_at = -1; nv = 0; no = 0;
    @(negedge clk);
    req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) begin
        for (int c = 0; c < 4; c++) ch_wave[c] = ch_wave[c] ^ 20'hFFFFF;
        ch_on = ~ch_on;
      end
      if (o_valid) begin nv++; if (v_at < 0) v_at = i; end
      if (o_overrun) begin no++; if (o_at < 0) o_at = i; end
      req = (i + 1 == rereq);
      rst = (i == rst_at);
    end
    req = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    set_ch(20'h0, 20'h0, 20'h0, 20'h0, 4'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_left", o_left, 20'h0);
    check("rst_right", o_right, 20'h0);
    check("rst_valid", o_valid, 1'b0);
    check("rst_overrun", o_overrun, 1'b0);
    check("rst_sound_on", o_sound_on, 1'b0);
    bus_read(16'hFF26, rd); check("nr52_rst", rd, 8'h70);
    ch_on = 4'b1010;
    bus_read(16'hFF26, rd); check("nr52_chon", rd, 8'h7A);

    bus_write(16'hFF24, 8'h77);
    bus_read(16'hFF24, rd); check("nr50_off_ignored", rd, 8'h00);

    bus_write(16'hFF26, 8'h80);
    check("sound_on", o_sound_on, 1'b1);
    ch_on = 4'hF;
    bus_read(16'hFF26, rd); check("nr52_on", rd, 8'hFF);
    bus_write(16'hFF24, 8'h77);
    bus_write(16'hFF25, 8'hFF);
    bus_read(16'hFF24, rd); check("nr50_rb", rd, 8'h77);
    bus_read(16'hFF25, rd); check("nr51_rb", rd, 8'hFF);

    set_ch(20'h1FFFF, 20'h1FFFF, 20'h1FFFF, 20'h1FFFF, 4'hF);
    run_sample(-1, -1, valid_at, ovr_at, n_valid, n_ovr);
    check("full_valid_at", valid_at, 6);
    check("full_nvalid", n_valid, 1);
    check("full_novr", n_ovr, 0);
    check("full_left", o_left, 20'h7FFFC);
    check("full_right", o_right, 20'h7FFFC);

    bus_write(16'hFF25, 8'h10);
    bus_write(16'hFF24, 8'h30);
    set_ch(20'h08000, 20'h12345, 20'h23456, 20'h34567, 4'hF);
    run_sample(-1, -1, valid_at, ovr_at, n_valid, n_ovr);
    check("ch1_valid_at", valid_at, 6);
    check("ch1_left", o_left, 20'h04000);
    check("ch1_right", o_right, 20'h0);

    bus_write(16'hFF25, 8'hA5);
    bus_write(16'hFF24, 8'h07);
    set_ch(20'h10000, 20'h20000, 20'h30000, 20'h40000, 4'b1011);
    run_sample(-1, -1, valid_at, ovr_at, n_valid, n_ovr);
    check("route_left", o_left, 20'h0C000);
    check("route_right", o_right, 20'h10000);

    bus_write(16'hFF25, 8'hFF);
    bus_write(16'hFF24, 8'h70);
    set_ch(20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 4'hF);
    run_sample(3, -1, valid_at, ovr_at, n_valid, n_ovr);
    check("ovr_valid_at", valid_at, 6);
    check("ovr_nvalid", n_valid, 1);
    check("ovr_at", ovr_at, 3);
    check("ovr_novr", n_ovr, 1);
    check("sat_left", o_left, 20'hFFFFF);
    check("sat_right", o_right, 20'h7FFFF);

    bus_write(16'hFF26, 8'h00);
    check("off_sound_on", o_sound_on, 1'b0);
    check("off_left", o_left, 20'h0);
    bus_read(16'hFF24, rd); check("off_nr50", rd, 8'h00);
    bus_read(16'hFF25, rd); check("off_nr51", rd, 8'h00);
    bus_write(16'hFF25, 8'hFF);
    bus_read(16'hFF25, rd); check("off_nr51_ignored", rd, 8'h00);
    ch_on = 4'b0101;
    bus_read(16'hFF26, rd); check("off_nr52", rd, 8'h75);
    set_ch(20'h1FFFF, 20'h1FFFF, 20'h1FFFF, 20'h1FFFF, 4'hF);
    run_sample(-1, -1, valid_at, ovr_at, n_valid, n_ovr);
    check("off_out_left", o_left, 20'h0);
    check("off_out_right", o_right, 20'h0);

    bus_write(16'hFF26, 8'h80);
    bus_write(16'hFF24, 8'h77);
    bus_write(16'hFF25, 8'hFF);
    set_ch(20'h1FFFF, 20'h1FFFF, 20'h1FFFF, 20'h1FFFF, 4'hF);
    run_sample(-1, 2, valid_at, ovr_at, n_valid, n_ovr);
    check("rst_mid_nvalid", n_valid, 0);
    check("rst_mid_left", o_left, 20'h0);
    check("rst_mid_right", o_right, 20'h0);
    check("rst_mid_sound_on", o_sound_on, 1'b0);
    bus_read(16'hFF24, rd); check("rst_mid_nr50", rd, 8'h00);

    bus_write(16'hFF26, 8'h80);
    bus_write(16'hFF24, 8'h77);
    bus_write(16'hFF25, 8'hFF);
    set_ch(20'h1FFFF, 20'h1FFFF, 20'h1FFFF, 20'h1FFFF, 4'hF);
    run_sample(-1, -1, valid_at, ovr_at, n_valid, n_ovr);
    check("post_rst_valid_at", valid_at, 6);
    check("post_rst_left", o_left, 20'h7FFFC);
    check("post_rst_right", o_right, 20'h7FFFC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
